// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the instruction-memory loader slice.
package imem_pkg;

    localparam int IMEM_DEPTH = 256;
    localparam int IMEM_AW    = 8;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } loader_state_t;

    // An invalid instruction word reads back as this value.
    localparam word_t NOP_WORD = 32'h0;

endpackage

// File: rtl/imem_loader_if.sv
// Bus bundle between the loader and its users (byte source and fetch stage).
//
// Byte stream handshake: a byte (in_byte/in_last) transfers on a rising clk
// edge where in_valid and in_ready are both high. in_ready depends only on the
// loader's registered state, never on in_valid. The source holds in_byte and
// in_last stable while in_valid is high and in_ready is low. A start pulse in
// the same cycle wins: the byte presented alongside it is not taken.
interface imem_loader_if #(
    parameter int AW = imem_pkg::IMEM_AW
) ();
    import imem_pkg::*;

    logic          start;
    logic          in_valid;
    byte_t         in_byte;
    logic          in_last;
    logic          in_ready;
    logic [AW-1:0] rd_addr;
    logic [63:0]   rd_data;
    logic [1:0]    rd_word_valid;
    logic [AW:0]   byte_count;
    logic          load_done;
    logic          overflow;
    loader_state_t state;      // loader FSM state, exposed for observation

    // Driver side: byte source plus fetch-stage read requester.
    modport master (
        output start, in_valid, in_byte, in_last, rd_addr,
        input  in_ready, rd_data, rd_word_valid, byte_count, load_done,
               overflow, state
    );

    // Loader side.
    modport slave (
        input  start, in_valid, in_byte, in_last, rd_addr,
        output in_ready, rd_data, rd_word_valid, byte_count, load_done,
               overflow, state
    );

endinterface

// File: rtl/imem_loader_byte_ram.sv
// DEPTH x 8 instruction byte storage: one synchronous write port and eight
// combinational read taps at raddr..raddr+7. Taps past the end read as zero.
module imem_byte_ram
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  byte_t         wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    byte_t       mem [DEPTH];
    logic [AW:0] tap_addr [8];

    // Write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Eight read taps, most significant byte first, zero beyond the array.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            tap_addr[i] = {1'b0, raddr} + (AW+1)'(i);
            if (tap_addr[i] < DEPTH_C) begin
                rdata[63-8*i -: 8] = mem[tap_addr[i][AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a byte stream, pads the image to a word
// boundary, tracks how many bytes are loaded and serves registered dual-word
// reads with per-word validity derived from the loaded byte count.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] FOUR_C  = (AW+1)'(4);

    loader_state_t state_q, state_d;
    logic [AW:0]   count_q, count_d, count_inc;
    logic          ovf_q, ovf_d;
    logic          we;
    byte_t         wdata;

    logic [63:0]   taps;
    logic [AW:0]   addr0, addr1;
    logic          valid0, valid1;
    logic [63:0]   rd_data_q;
    logic [1:0]    rd_valid_q;

    assign count_inc = count_q + ONE_C;

    // FSM state, byte counter and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next state, memory write and counter update; start overrides everything.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        wdata   = '0;
        if (bus.start) begin
            state_d = LOAD;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (bus.in_valid) begin
                        we      = 1'b1;
                        wdata   = bus.in_byte;
                        count_d = count_inc;
                        if (bus.in_last) begin
                            state_d = (count_inc[1:0] == 2'b00) ? DONE : PAD;
                        end else if (count_inc == DEPTH_C) begin
                            ovf_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                PAD: begin
                    we      = 1'b1;
                    wdata   = 8'h00;
                    count_d = count_inc;
                    if (count_inc[1:0] == 2'b00) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    imem_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (count_q[AW-1:0]),
        .wdata (wdata),
        .raddr (bus.rd_addr),
        .rdata (taps)
    );

    // Word k is valid only when all four of its bytes lie below the count.
    always_comb begin
        addr0  = {1'b0, bus.rd_addr};
        addr1  = addr0 + FOUR_C;
        valid0 = (addr0 + FOUR_C) <= count_q;
        valid1 = (addr1 + FOUR_C) <= count_q;
    end

    // Registered read port; sees memory and count as they were before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 2'b00;
        end else begin
            rd_data_q  <= {valid0 ? taps[63:32] : NOP_WORD,
                           valid1 ? taps[31:0]  : NOP_WORD};
            rd_valid_q <= {valid0, valid1};
        end
    end

    assign bus.in_ready      = (state_q == LOAD);
    assign bus.load_done     = (state_q == DONE);
    assign bus.overflow      = ovf_q;
    assign bus.byte_count    = count_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_word_valid = rd_valid_q;
    assign bus.state         = state_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader and dual-word read port for the instruction memory. Accepts instruction bytes over a valid/ready stream, writes them into a 256-byte instruction memory, pads the image to a 4-byte boundary, and reports completion. It is the writer side of the instruction memory that the dual-issue fetch stage reads eight bytes per cycle from. It replaces file-based preloading, and provides explicit per-word validity so the fetch stage no longer depends on X-detection to find the end of the program.

## Interface
- DEPTH, 256, memory size in bytes; power of two, multiple of 4.
- AW, 8, address width; equals log2(DEPTH).

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new load and clears the byte count.
- in_valid  in  1  in_byte/in_last are valid.
- in_byte  in  8  instruction byte, program order, MSB byte of each word first.
- in_last  in  1  marks the final byte of the image.
- in_ready  out  1  loader accepts a byte this cycle.
- rd_addr  in  AW  byte address of instr word 0; word 1 is at rd_addr+4.
- rd_data  out  64  {word0, word1}; each word is {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- rd_word_valid  out  2  bit1 = word0 fully loaded, bit0 = word1 fully loaded.
- byte_count  out  AW+1  bytes written in the current image, including padding.
- load_done  out  1  image complete; held until start or rst.
- overflow  out  1  image hit DEPTH without in_last; sticky until start or rst.

## Operation
- States: IDLE, LOAD, PAD, DONE.
- IDLE: in_ready=0. start -> LOAD.
- LOAD: in_ready=1.
  - A byte is accepted when in_valid && in_ready. The accepted byte writes mem[byte_count], then byte_count increments.
  - Accepted with in_last, new count%4==0 -> DONE.
  - Accepted with in_last, new count%4!=0 -> PAD.
  - Accepted without in_last, new count==DEPTH -> overflow=1, DONE.
- PAD: in_ready=0. Writes 8'h00 to mem[byte_count] each cycle, increments, and goes to DONE when count%4==0. Takes at most 3 cycles.
- DONE: load_done=1, in_ready=0.
- start in any state, including mid-LOAD and mid-PAD, has these effects next cycle:
  - byte_count=0, load_done=0, overflow=0, state LOAD.
  - A byte presented in the same cycle as start is not accepted, because in_ready is driven from the current state and start takes priority.
- Memory contents are not cleared by start or rst. Validity is derived only from byte_count.
- Read path:
  - Word k (k=0,1) starts at address a_k = rd_addr + 4k, computed in AW+1 bits with no wrap.
  - Word k is valid iff a_k + 4 <= byte_count.
  - An invalid word returns 32'h0 on rd_data.
  - rd_addr need not be aligned.
  - Reads are permitted in every state.

## Timing
- Reset values: state IDLE, in_ready 0, rd_data 0, rd_word_valid 0, byte_count 0, load_done 0, overflow 0.
- in_ready is a function of the registered state only, with no combinational path from in_valid.
- Write latency: a byte accepted at edge N is in memory and counted after edge N.
- Read latency: rd_data and rd_word_valid are registered, 1 cycle after rd_addr.
  - They reflect memory and byte_count as they were before the same edge's write (read-old semantics).
  - A byte written at edge N is visible to a read sampled at edge N+1, and appears on rd_data after edge N+1.
- load_done rises on the edge that writes the final data or pad byte.
- rst asserted mid-LOAD aborts immediately. A partial image is discarded because byte_count returns to 0.

## Structure
- Package imem_pkg:
  - IMEM_DEPTH, IMEM_AW constants.
  - byte_t and word_t typedefs.
  - loader_state_t enum {IDLE, LOAD, PAD, DONE}.
  - NOP_WORD = 32'h0.
- Sub-module imem_byte_ram holds the DEPTH x 8 storage: one synchronous write port and eight combinational read taps at addr..addr+7, with out-of-range taps returning 0.
- imem_loader holds the FSM, counter, validity compare and output registers.

## Test plan
- Reset then idle: rst pulse, no start -> in_ready=0, byte_count=0, rd_word_valid=2'b00, rd_data=0.
- Aligned load: start, then bytes 00 00 00 33 00 10 00 B3 with last on the 8th byte.
  - Expect byte_count=8 and load_done one cycle after the final acceptance.
  - rd_addr=0 -> rd_data=64'h00000033_001000B3, rd_word_valid=2'b11.
- Padding: start, bytes AA BB CC DD EE with last on EE.
  - Expect 3 PAD cycles with in_ready=0, then byte_count=8.
  - rd_addr=4 -> word0=32'hEE000000 valid; word1 invalid and 0.
- Backpressure and gaps: in_valid toggled randomly over 16 bytes -> every accepted byte lands in order, byte_count=16, no duplicates.
- Overflow: start, then 256 bytes with no last -> overflow=1, load_done=1, in_ready=0, byte_count=256.
  - rd_addr=252 -> word0 valid, word1 invalid.
- Restart and async reset:
  - start after 6 bytes -> byte_count=0 next cycle, the same-cycle byte is not accepted, and the new image loads from address 0.
  - rst mid-PAD -> all outputs return to reset values without waiting for a clock edge.
